// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and defaults for the divider arbiter slice.
//   state_t      : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   N_REQ_DEF    : default requester count
//   WIDTH_DEF    : default operand/quotient width (Q6.4)
//   FRAC_BITS    : fraction bits of the Q6.4 format
//   TIMEOUT_DEF  : default watchdog limit (only used with DIV_ARB_TIMEOUT_EN)
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 10;
  localparam int FRAC_BITS   = 4;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: bundle between the arbiter and the shared divider.
//   master (arbiter side): drives div_a, div_b, div_start, div_sclr;
//                          samples div_busy, div_valid, div_q, div_dvz, div_ovf
//   slave  (divider side): the mirror image
// Handshake: div_start is a one-cycle pulse with div_a/div_b valid in the same
// cycle and held stable until div_valid; div_valid is a one-cycle pulse with
// div_q/div_dvz/div_ovf valid in that cycle; no ready back-pressure exists, so
// the arbiter only starts when div_busy is low. div_sclr clears the divider.
interface div_arbiter_if
  import div_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_start;
  logic             div_sclr;
  logic             div_busy;
  logic             div_valid;
  logic [WIDTH-1:0] div_q;
  logic             div_dvz;
  logic             div_ovf;

  modport master (
    output div_a, div_b, div_start, div_sclr,
    input  div_busy, div_valid, div_q, div_dvz, div_ovf
  );

  modport slave (
    input  div_a, div_b, div_start, div_sclr,
    output div_busy, div_valid, div_q, div_dvz, div_ovf
  );
endinterface

// File: rtl/div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req    : request vector
//   ptr    : index with highest priority this round
//   onehot : one-hot winner (first set bit of req at or above ptr, wrapping)
//   idx    : binary index of the winner
//   any    : at least one request present
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down to ptr itself so the closest
  // requester at or after ptr is the last (winning) assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    pos    = '0;
    any    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % N);
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one Q6.4 divider among N_REQ requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester request level, held until gnt
//   req_a/req_b : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt         : one-hot pulse when the operands are issued
//   resp_valid  : one-hot pulse when the result for that requester is ready
//   resp_q/resp_dvz/resp_ovf/resp_tout : result, held until the next response
//   dif         : divider bundle (master side)
//   state_dbg   : current FSM state
// Optional watchdog: define DIV_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles (result 0, resp_tout=1, divider cleared via div_sclr).
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_q,
  output logic                   resp_dvz,
  output logic                   resp_ovf,
  output logic                   resp_tout,
  div_arbiter_if.master          dif,
  output state_t                 state_dbg
);
  localparam int IW = $clog2(N_REQ);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;
  logic [WIDTH-1:0] div_a_r;
  logic [WIDTH-1:0] div_b_r;
  logic             div_start_r;
  logic             div_sclr_r;
  logic [WIDTH-1:0] ops_a [N_REQ];
  logic [WIDTH-1:0] ops_b [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign ops_a[g] = req_a[g*WIDTH +: WIDTH];
    assign ops_b[g] = req_b[g*WIDTH +: WIDTH];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          resp_tout_r;
  assign resp_tout = resp_tout_r;
`else
  // No watchdog in this build; TIMEOUT is never negative, so this is 0.
  assign resp_tout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      win_idx     <= '0;
      gnt         <= '0;
      resp_valid  <= '0;
      resp_q      <= '0;
      resp_dvz    <= 1'b0;
      resp_ovf    <= 1'b0;
      div_a_r     <= '0;
      div_b_r     <= '0;
      div_start_r <= 1'b0;
      // Clears the divider through the first edge after release.
      div_sclr_r  <= 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      resp_tout_r <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low every cycle.
      gnt         <= '0;
      resp_valid  <= '0;
      div_start_r <= 1'b0;
      div_sclr_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && !dif.div_busy && !div_sclr_r) begin
            win_idx     <= pick_idx;
            div_a_r     <= ops_a[pick_idx];
            div_b_r     <= ops_b[pick_idx];
            gnt         <= pick_oh;
            div_start_r <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ptr   <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
          state <= WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (dif.div_valid) begin
            resp_q     <= dif.div_q;
            resp_dvz   <= dif.div_dvz;
            resp_ovf   <= dif.div_ovf;
            resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            state      <= RESP;
`ifdef DIV_ARB_TIMEOUT_EN
            resp_tout_r <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Divider hung: answer with an empty result and reset it.
            resp_q      <= '0;
            resp_dvz    <= 1'b0;
            resp_ovf    <= 1'b0;
            resp_tout_r <= 1'b1;
            resp_valid  <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            div_sclr_r  <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dif.div_a     = div_a_r;
  assign dif.div_b     = div_b_r;
  assign dif.div_start = div_start_r;
  assign dif.div_sclr  = div_sclr_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 10;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   gnt, resp_valid;
  logic [W-1:0]   resp_q;
  logic           resp_dvz, resp_ovf, resp_tout;
  state_t         state_dbg;

  div_arbiter_if #(.WIDTH(W)) dif ();

  div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_q     (resp_q),
    .resp_dvz   (resp_dvz),
    .resp_ovf   (resp_ovf),
    .resp_tout  (resp_tout),
    .dif        (dif),
    .state_dbg  (state_dbg)
  );

  // ---------------- divider model ----------------
  function automatic logic [11:0] div_ref(logic [W-1:0] a, logic [W-1:0] b);
    int unsigned num, quo;
    if (b == '0) return {1'b1, 1'b0, 10'h3FF};
    num = int'(a) << 4;
    quo = num / int'(b);
    if (quo > 1023) return {1'b0, 1'b1, 10'h3FF};
    return {2'b00, quo[9:0]};
  endfunction

  logic         force_busy = 1'b0;
  logic         hang = 1'b0;
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;

  assign dif.div_busy = m_busy | force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      m_a           <= '0;
      m_b           <= '0;
      dif.div_valid <= 1'b0;
      dif.div_q     <= '0;
      dif.div_dvz   <= 1'b0;
      dif.div_ovf   <= 1'b0;
    end else begin
      dif.div_valid <= 1'b0;
      if (dif.div_sclr) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else if (dif.div_start) begin
        m_a    <= dif.div_a;
        m_b    <= dif.div_b;
        m_busy <= 1'b1;
        m_cnt  <= LAT;
      end else if (m_busy && !hang) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          {dif.div_dvz, dif.div_ovf, dif.div_q} <= div_ref(m_a, m_b);
          dif.div_valid <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  // exp entry: {idx[2:0], tout, dvz, ovf, q[9:0]}
  logic [15:0] exp_q[$];
  logic [2:0]  gnt_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  int last_resp_cyc = 0;
  int n_start = 0;
  logic sclr_at_resp = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mk_exp(int idx, logic [2:0] flags_tdo, logic [W-1:0] q);
    logic [2:0] i3;
    i3 = 3'(idx);
    return {i3, flags_tdo, q};
  endfunction

  // Expected entry from the reference divider: flags as {tout, dvz, ovf}.
  function automatic logic [15:0] mk_ref(int idx, logic [W-1:0] a, logic [W-1:0] b);
    logic [11:0] r;
    r = div_ref(a, b);
    return mk_exp(idx, {1'b0, r[11], r[10]}, r[9:0]);
  endfunction

  task automatic set_ops(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One clock: observe at the falling edge, score grants and responses,
  // drop req for whoever was granted.
  task automatic step();
    logic [15:0] e;
    logic [2:0]  gi;
    @(negedge clk);
    cyc++;
    if (dif.div_start) n_start++;
    if (|gnt) begin
      last_gnt_cyc = cyc;
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        gi = gnt_q.pop_front();
        check("gnt_order", 32'(gnt), 32'd1 << gi);
        check("start_with_gnt", 32'(dif.div_start), 32'd1);
      end
      req = req & ~gnt;
    end
    if (|resp_valid) begin
      last_resp_cyc = cyc;
      sclr_at_resp  = dif.div_sclr;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_valid", 32'(resp_valid), 32'd1 << e[15:13]);
        check("resp_q", 32'(resp_q), 32'(e[9:0]));
        check("resp_flags", 32'({resp_tout, resp_dvz, resp_ovf}), 32'(e[12:10]));
      end
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((gnt_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", 32'(gnt_q.size() + exp_q.size()), 32'd0);
    gnt_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_state(state_t s, int budget);
    int n;
    n = 0;
    while (state_dbg != s && n < budget) begin
      step();
      n++;
    end
    check("reach_state", 32'(state_dbg), 32'(s));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0, s0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_start", 32'(dif.div_start), 32'd0);
    check("rst_sclr", 32'(dif.div_sclr), 32'd1);
    check("rst_div_a", 32'(dif.div_a), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    #1 check("sclr_after_release", 32'(dif.div_sclr), 32'd1);
    step();
    check("sclr_cleared", 32'(dif.div_sclr), 32'd0);

    // All four at once: grant order 0,1,2,3 from pointer 0
    set_ops(0, 10'd520, 10'd116);
    set_ops(1, 10'd832, 10'd97);
    set_ops(2, 10'd100, 10'd50);
    set_ops(3, 10'd300, 10'd7);
    for (int i = 0; i < N; i++) begin
      gnt_q.push_back(3'(i));
      exp_q.push_back(mk_ref(i, req_a[i*W +: W], req_b[i*W +: W]));
    end
    req = 4'b1111;
    drain(200);
    step();

    // Single request: 32.5 / 7.25 -> 4.4375, one start, gnt in the
    // cycle after the IDLE cycle that sampled req
    set_ops(0, 10'b1000001000, 10'b0001110100);
    gnt_q.push_back(3'd0);
    exp_q.push_back(mk_exp(0, 3'b000, 10'b0001000111));
    s0 = n_start;
    c0 = cyc;
    req = 4'b0001;
    drain(50);
    check("gnt_latency", 32'(last_gnt_cyc - c0), 32'd1);
    check("single_start", 32'(n_start - s0), 32'd1);

    // Serve requester 2 -> pointer 3
    set_ops(2, 10'd160, 10'd32);
    gnt_q.push_back(3'd2);
    exp_q.push_back(mk_ref(2, 10'd160, 10'd32));
    req = 4'b0100;
    drain(50);

    // 0101 after 2: 0 before 2; flags dvz (63.9375/0) then ovf (63/0.75)
    set_ops(0, 10'd1023, 10'd0);
    set_ops(2, 10'd1008, 10'd12);
    gnt_q.push_back(3'd0);
    gnt_q.push_back(3'd2);
    exp_q.push_back(mk_exp(0, 3'b010, 10'h3FF));
    exp_q.push_back(mk_exp(2, 3'b001, 10'h3FF));
    req = 4'b0101;
    drain(100);

    // Serve 0 -> pointer 1, then 0111 -> 1,2,0
    set_ops(0, 10'd64, 10'd16);
    gnt_q.push_back(3'd0);
    exp_q.push_back(mk_ref(0, 10'd64, 10'd16));
    req = 4'b0001;
    drain(50);
    set_ops(1, 10'd500, 10'd3);
    set_ops(2, 10'd17, 10'd999);
    set_ops(0, 10'd1, 10'd1);
    gnt_q.push_back(3'd1);
    gnt_q.push_back(3'd2);
    gnt_q.push_back(3'd0);
    exp_q.push_back(mk_ref(1, 10'd500, 10'd3));
    exp_q.push_back(mk_ref(2, 10'd17, 10'd999));
    exp_q.push_back(mk_ref(0, 10'd1, 10'd1));
    req = 4'b0111;
    drain(150);

    // Divider busy holds the request off
    force_busy = 1'b1;
    set_ops(2, 10'd200, 10'd40);
    gnt_q.push_back(3'd2);
    exp_q.push_back(mk_ref(2, 10'd200, 10'd40));
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      check("busy_hold", 32'({gnt, dif.div_start}), 32'd0);
    end
    force_busy = 1'b0;
    drain(50);

    // Reset while waiting on the divider aborts the transfer
    set_ops(1, 10'd300, 10'd30);
    gnt_q.push_back(3'd1);
    req = 4'b0010;
    wait_state(WAIT, 10);
    rst_n = 1'b0;
    #1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_q", 32'(resp_q), 32'd0);
    check("abort_div_b", 32'(dif.div_b), 32'd0);
    check("abort_sclr", 32'(dif.div_sclr), 32'd1);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    step();
    step();
    rst_n = 1'b1;
    #1 check("abort_sclr_release", 32'(dif.div_sclr), 32'd1);
    step();
    check("abort_sclr_cleared", 32'(dif.div_sclr), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("abort_no_resp", 32'(exp_q.size()), 32'd0);

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider never answers: watchdog response 64 cycles into WAIT
    hang = 1'b1;
    set_ops(3, 10'd100, 10'd10);
    gnt_q.push_back(3'd3);
    exp_q.push_back(mk_exp(3, 3'b100, 10'd0));
    req = 4'b1000;
    wait_state(WAIT, 10);
    c0 = cyc;
    drain(100);
    check("tout_latency", 32'(last_resp_cyc - c0), 32'd64);
    check("tout_sclr", 32'(sclr_at_resp), 32'd1);
    hang = 1'b0;
    set_ops(0, 10'd80, 10'd20);
    gnt_q.push_back(3'd0);
    exp_q.push_back(mk_ref(0, 10'd80, 10'd20));
    req = 4'b0001;
    drain(50);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
